// File: rtl/pipelined_addsub_pkg.sv
// Shared configuration helpers for the pipelined adder/subtractor: slice-width derivation,
// geometry legality check and the per-stage control record.
package pipelined_addsub_pkg;

   localparam int DEF_WIDTH  = 32;
   localparam int DEF_STAGES = 4;

   // Control state a stage carries alongside its partial sum.
   typedef struct packed {
      logic vld;
      logic carry;
      logic zero;
   } stage_ctl_t;

   function automatic int slice_width(input int width, input int stages);
      return width / stages;
   endfunction

   function automatic bit cfg_ok(input int width, input int stages);
      return (stages >= 1) && (width >= stages) && ((width % stages) == 0);
   endfunction

endpackage

// File: rtl/pipelined_addsub_if.sv
// Operand/result handshake bundle for pipelined_addsub; ADDER_FLAGS_EN adds the ovf/zero/neg
// result flags.
interface pipelined_addsub_if
   import pipelined_addsub_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH
);
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             sub;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] sum;
   logic             cout;
`ifdef ADDER_FLAGS_EN
   logic             ovf;
   logic             zero;
   logic             neg;
`endif

   modport master (
      output in_valid, a, b, sub, out_ready,
      input  in_ready, out_valid, sum, cout
`ifdef ADDER_FLAGS_EN
      , input ovf, zero, neg
`endif
   );

   modport slave (
      input  in_valid, a, b, sub, out_ready,
      output in_ready, out_valid, sum, cout
`ifdef ADDER_FLAGS_EN
      , output ovf, zero, neg
`endif
   );

endinterface

// File: rtl/addsub_slice.sv
// SW-bit combinational ripple of full adders; cmsb (carry into the top bit) exists only when
// ADDER_FLAGS_EN is defined.
module addsub_slice #(
   parameter int SW = 8
) (
   input  logic [SW-1:0] a,
   input  logic [SW-1:0] b,
   input  logic          cin,
   output logic [SW-1:0] s,
`ifdef ADDER_FLAGS_EN
   output logic          cmsb,
`endif
   output logic          cout
);

   logic [SW:0] c;

   always_comb begin
      c    = '0;
      s    = '0;
      c[0] = cin;
      for (int i = 0; i < SW; i++) begin
         s[i]   = a[i] ^ b[i] ^ c[i];
         c[i+1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
      end
   end

   assign cout = c[SW];
`ifdef ADDER_FLAGS_EN
   assign cmsb = c[SW-1];
`endif

endmodule

// File: rtl/pipelined_addsub.sv
// Pipelined ripple-carry add/sub: one SW-bit slice per stage, carry registered between stages,
// latency STAGES, empty stages fill under backpressure. ADDER_FLAGS_EN adds ovf/zero/neg outputs.
module pipelined_addsub
   import pipelined_addsub_pkg::*;
#(
   parameter int WIDTH  = DEF_WIDTH,
   parameter int STAGES = DEF_STAGES
) (
   input logic              clk,
   input logic              rst,
   pipelined_addsub_if.slave io
);

   localparam int SW = slice_width(WIDTH, STAGES);

   if (!cfg_ok(WIDTH, STAGES)) begin : g_cfg_err
      $error("pipelined_addsub: WIDTH must be a non-zero multiple of STAGES");
   end

   logic [STAGES-1:0] vld;
   logic [STAGES-1:0] rdy;
   logic [STAGES-1:0] upv;
   logic [WIDTH-1:0]  b_in;

   assign b_in = io.b ^ {WIDTH{io.sub}};
   // upv[k] is the valid of whatever feeds stage k.
   assign upv  = STAGES'({vld, io.in_valid});

   // Ready ripples back from the output; a hole anywhere lets everything upstream of it move.
   always_comb begin : p_rdy
      logic dn;
      dn  = io.out_ready;
      rdy = '0;
      for (int k = STAGES - 1; k >= 0; k--) begin
         rdy[k] = !vld[k] || dn;
         dn     = rdy[k];
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         vld <= '0;
      end else begin
         for (int k = 0; k < STAGES; k++) begin
            if (rdy[k]) vld[k] <= upv[k];
         end
      end
   end

`ifdef ADDER_FLAGS_EN
   logic ovf_r;
`endif

   for (genvar k = 0; k < STAGES; k++) begin : g_stg
      localparam int PW  = (k + 1) * SW;
      localparam int REM = WIDTH - PW;

      logic          ld;
      logic [SW-1:0] sa;
      logic [SW-1:0] sb;
      logic [SW-1:0] ss;
      logic          sci;
      logic          sco;
      logic [PW-1:0] ps_d;
      logic [PW-1:0] ps_r;
      logic          c_r;
`ifdef ADDER_FLAGS_EN
      logic          cm;
      logic          z_d;
      logic          z_r;
`endif

      assign ld = rdy[k] && upv[k];

      if (k == 0) begin : g_src
         assign sa   = io.a[SW-1:0];
         assign sb   = b_in[SW-1:0];
         assign sci  = io.sub;
         assign ps_d = ss;
`ifdef ADDER_FLAGS_EN
         assign z_d  = (ss == '0);
`endif
      end else begin : g_src
         assign sa   = g_stg[k-1].g_opr.a_r[SW-1:0];
         assign sb   = g_stg[k-1].g_opr.b_r[SW-1:0];
         assign sci  = g_stg[k-1].c_r;
         assign ps_d = {ss, g_stg[k-1].ps_r};
`ifdef ADDER_FLAGS_EN
         assign z_d  = (ss == '0) && g_stg[k-1].z_r;
`endif
      end

      addsub_slice #(.SW(SW)) u_slice (
         .a    (sa),
         .b    (sb),
         .cin  (sci),
         .s    (ss),
`ifdef ADDER_FLAGS_EN
         .cmsb (cm),
`endif
         .cout (sco)
      );

      // Operand bits not yet consumed, shifted so the next slice sits at bit 0.
      if (REM > 0) begin : g_opr
         logic [REM-1:0] a_r;
         logic [REM-1:0] b_r;
         if (k == 0) begin : g_ld
            always_ff @(posedge clk) begin
               if (ld) begin
                  a_r <= io.a[WIDTH-1:SW];
                  b_r <= b_in[WIDTH-1:SW];
               end
            end
         end else begin : g_ld
            always_ff @(posedge clk) begin
               if (ld) begin
                  a_r <= g_stg[k-1].g_opr.a_r[REM+SW-1:SW];
                  b_r <= g_stg[k-1].g_opr.b_r[REM+SW-1:SW];
               end
            end
         end
      end

      if (k == STAGES - 1) begin : g_reg
         always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
               ps_r  <= '0;
               c_r   <= 1'b0;
`ifdef ADDER_FLAGS_EN
               z_r   <= 1'b0;
               ovf_r <= 1'b0;
`endif
            end else if (ld) begin
               ps_r  <= ps_d;
               c_r   <= sco;
`ifdef ADDER_FLAGS_EN
               z_r   <= z_d;
               ovf_r <= cm ^ sco;
`endif
            end
         end
      end else begin : g_reg
         always_ff @(posedge clk) begin
            if (ld) begin
               ps_r <= ps_d;
               c_r  <= sco;
`ifdef ADDER_FLAGS_EN
               z_r  <= z_d;
`endif
            end
         end
      end
   end

   assign io.in_ready  = rdy[0];
   assign io.out_valid = vld[STAGES-1];
   assign io.sum       = g_stg[STAGES-1].ps_r;
   assign io.cout      = g_stg[STAGES-1].c_r;
`ifdef ADDER_FLAGS_EN
   assign io.ovf       = ovf_r;
   assign io.zero      = g_stg[STAGES-1].z_r;
   assign io.neg       = g_stg[STAGES-1].ps_r[WIDTH-1];
`endif

endmodule

// File: tb/tb_pipelined_addsub.sv
// Scoreboard bench for pipelined_addsub: random and directed operands against an arithmetic
// reference model, with stall, random backpressure and mid-flight reset phases.
module tb_pipelined_addsub;

   localparam int W = 32;
   localparam int S = 4;

   typedef struct {
      logic [W-1:0] sum;
      logic         cout;
      logic         ovf;
      logic         zero;
      logic         neg;
      bit           chk_lat;
      int           acc_cyc;
   } exp_t;

   logic clk = 1'b0;
   logic rst;
   int   errors = 0;
   int   checks = 0;
   int   cyc    = 0;
   bit   rand_bp = 1'b0;
   exp_t sb[$];
   exp_t mon_e;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   pipelined_addsub_if #(.WIDTH(W)) io ();

   pipelined_addsub #(.WIDTH(W), .STAGES(S)) dut (
      .clk (clk),
      .rst (rst),
      .io  (io)
   );

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got %0h, expected %0h", name, act, req);
      end
   endtask

   // Reference: plain modular arithmetic; sub carry-out means "no borrow" (a >= b unsigned).
   function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b, input logic sub);
      exp_t       e;
      logic [W:0] wide;
      if (!sub) begin
         wide   = {1'b0, a} + {1'b0, b};
         e.sum  = wide[W-1:0];
         e.cout = wide[W];
         e.ovf  = (a[W-1] == b[W-1]) && (e.sum[W-1] != a[W-1]);
      end else begin
         e.sum  = a - b;
         e.cout = (a >= b);
         e.ovf  = (a[W-1] != b[W-1]) && (e.sum[W-1] != a[W-1]);
      end
      e.zero    = (e.sum == '0);
      e.neg     = e.sum[W-1];
      e.chk_lat = 1'b0;
      e.acc_cyc = 0;
      return e;
   endfunction

   // Called at posedge+1; holds the beat until accepted, returns at posedge+1 after acceptance.
   task automatic send(input logic [W-1:0] a, input logic [W-1:0] b, input logic sub, input bit lat);
      int   waited;
      exp_t e;
      waited      = 0;
      io.in_valid = 1'b1;
      io.a        = a;
      io.b        = b;
      io.sub      = sub;
      @(negedge clk);
      while (!io.in_ready && waited < 200) begin
         waited++;
         @(negedge clk);
      end
      if (!io.in_ready) begin
         check("in_ready_wait", io.in_ready, 1);
      end else begin
         e         = model(a, b, sub);
         e.chk_lat = lat;
         e.acc_cyc = cyc;
         sb.push_back(e);
      end
      @(posedge clk);
      #1 io.in_valid = 1'b0;
   endtask

   task automatic wait_drain(input int budget);
      int n;
      n = 0;
      while (sb.size() != 0 && n < budget) begin
         n++;
         @(negedge clk);
      end
      check("drain_queue_empty", sb.size(), 0);
      @(posedge clk);
      #1;
   endtask

   // Monitor: every output transfer pops the oldest expectation.
   initial begin
      forever begin
         @(negedge clk);
         if (!rst && io.out_valid && io.out_ready) begin
            if (sb.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_result: got sum %0h with no beat outstanding", io.sum);
            end else begin
               mon_e = sb.pop_front();
               check("sum", io.sum, mon_e.sum);
               check("cout", io.cout, mon_e.cout);
`ifdef ADDER_FLAGS_EN
               check("ovf", io.ovf, mon_e.ovf);
               check("zero", io.zero, mon_e.zero);
               check("neg", io.neg, mon_e.neg);
`endif
               if (mon_e.chk_lat) check("latency", cyc - mon_e.acc_cyc, S);
            end
         end
      end
   end

   // Random downstream backpressure, active only while rand_bp is set.
   initial begin
      forever begin
         @(posedge clk);
         #1;
         if (rand_bp) io.out_ready = 1'($urandom_range(0, 1));
      end
   end

   initial begin
      #400000;
      $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
      $fatal(1);
   end

   initial begin
      int   t0;
      int   acc;
      bit   have;
      exp_t e;
      rst          = 1'b1;
      io.in_valid  = 1'b0;
      io.a         = '0;
      io.b         = '0;
      io.sub       = 1'b0;
      io.out_ready = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      check("reset_out_valid", io.out_valid, 0);
      check("reset_in_ready", io.in_ready, 1);
      check("reset_sum", io.sum, 0);
      check("reset_cout", io.cout, 0);
      rst = 1'b0;
      @(negedge clk);
      check("in_ready_after_release", io.in_ready, 1);
      @(posedge clk);
      #1;

      // Directed: simple add, wrap, signed overflow, subtract with and without borrow.
      send(32'h0000_0005, 32'h0000_0003, 1'b0, 1'b1);
      wait_drain(20);
      send(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b1);
      send(32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b1);
      send(32'h0000_0003, 32'h0000_0005, 1'b1, 1'b1);
      send(32'h0000_0005, 32'h0000_0003, 1'b1, 1'b1);
      send(32'h8000_0000, 32'h0000_0001, 1'b1, 1'b1);
      wait_drain(20);

      // Full-throughput random stream: 100 beats must take 100 cycles.
      t0 = cyc;
      for (int i = 0; i < 100; i++) send($urandom, $urandom, 1'($urandom_range(0, 1)), 1'b1);
      check("throughput_cycles", cyc - t0, 100);
      wait_drain(40);

      // Hard stall: exactly S beats fit, then in_ready stays low.
      io.out_ready = 1'b0;
      acc  = 0;
      have = 1'b0;
      for (int i = 0; i < 10; i++) begin
         if (!have) begin
            io.a   = $urandom;
            io.b   = $urandom;
            io.sub = 1'($urandom_range(0, 1));
            have   = 1'b1;
         end
         io.in_valid = 1'b1;
         @(negedge clk);
         if (io.in_ready) begin
            e = model(io.a, io.b, io.sub);
            sb.push_back(e);
            acc++;
            have = 1'b0;
         end
         @(posedge clk);
         #1;
      end
      check("stall_accepted", acc, S);
      check("stall_in_ready", io.in_ready, 0);
      io.in_valid  = 1'b0;
      io.out_ready = 1'b1;
      wait_drain(40);

      // Random backpressure with a continuous source.
      rand_bp = 1'b1;
      for (int i = 0; i < 60; i++) send($urandom, $urandom, 1'($urandom_range(0, 1)), 1'b0);
      rand_bp = 1'b0;
      @(posedge clk);
      #1 io.out_ready = 1'b1;
      wait_drain(100);

      // Reset with three beats in flight: they collapse forward, then must vanish.
      io.out_ready = 1'b0;
      for (int i = 0; i < 3; i++) send($urandom, $urandom, 1'b0, 1'b0);
      @(posedge clk);
      #1;
      check("prereset_out_valid", io.out_valid, 1);
      rst = 1'b1;
      #1;
      sb.delete();
      check("midreset_out_valid", io.out_valid, 0);
      check("midreset_sum", io.sum, 0);
      check("midreset_cout", io.cout, 0);
      @(posedge clk);
      @(posedge clk);
      #1 rst = 1'b0;
      io.out_ready = 1'b1;
      @(negedge clk);
      check("postreset_in_ready", io.in_ready, 1);
      check("postreset_out_valid", io.out_valid, 0);
      repeat (10) @(posedge clk);
      #1;
      send(32'h1234_5678, 32'h0FED_CBA9, 1'b0, 1'b1);
      send(32'h0000_0000, 32'h0000_0000, 1'b1, 1'b1);
      wait_drain(20);

      check("final_queue_empty", sb.size(), 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
